draw_cmd_seq: RTL

Display-list sequencer for the draw block. It pops 32-bit command words from the DRAWCMD FIFO and decodes SETFRAME, SETDRAWAREA, SETFCOLOR, PATBLT and EODL. For each PATBLT it clips the rectangle against the draw area and the frame, then hands one rectangle job to the pattern-fill engine. It sits between the register/FIFO block (DRAWCTRL/DRAWSTAT/DRAWINT) and the AXI write engine.

---
 rtl/draw_cmd_pkg.sv | 18 +
 rtl/draw_clip.sv | 32 +++
 rtl/draw_cmd_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/draw_cmd_pkg.sv
// draw_cmd_pkg: opcodes, sequencer states and rectangle type shared by the draw command sequencer
package draw_cmd_pkg;
  localparam int CW = 11;
  localparam logic [7:0] OP_SETFRAME    = 8'h20;
  localparam logic [7:0] OP_SETDRAWAREA = 8'h21;
  localparam logic [7:0] OP_SETFCOLOR   = 8'h23;
  localparam logic [7:0] OP_PATBLT      = 8'h81;
  localparam logic [7:0] OP_EODL        = 8'h0F;
  typedef enum logic [3:0] {
    S_IDLE, S_OP, S_ARG1, S_ARG2, S_CLIP, S_ADDR, S_ISSUE, S_WAIT, S_FIN, S_ERR
  } state_t;
  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [CW-1:0] w;
    logic [CW-1:0] h;
  } rect_t;
endpackage

// File: rtl/draw_clip.sv
// draw_clip: intersects pattern rect with draw area and frame; ports: pat, area, fw, fh in; x0, y0, w, h, empty out
module draw_clip
  import draw_cmd_pkg::*;
(
  input  rect_t         pat,
  input  rect_t         area,
  input  logic [CW-1:0] fw,
  input  logic [CW-1:0] fh,
  output logic [CW-1:0] x0,
  output logic [CW-1:0] y0,
  output logic [CW-1:0] w,
  output logic [CW-1:0] h,
  output logic          empty
);
  logic [CW:0] px1, ax1, py1, ay1, xm, ym, x1, y1;
  always_comb begin
    x0    = pat.x > area.x ? pat.x : area.x;
    y0    = pat.y > area.y ? pat.y : area.y;
    px1   = {1'b0, pat.x} + {1'b0, pat.w};
    ax1   = {1'b0, area.x} + {1'b0, area.w};
    py1   = {1'b0, pat.y} + {1'b0, pat.h};
    ay1   = {1'b0, area.y} + {1'b0, area.h};
    xm    = px1 < ax1 ? px1 : ax1;
    ym    = py1 < ay1 ? py1 : ay1;
    x1    = xm < {1'b0, fw} ? xm : {1'b0, fw};
    y1    = ym < {1'b0, fh} ? ym : {1'b0, fh};
    empty = (x1 <= {1'b0, x0}) || (y1 <= {1'b0, y0});
    // x1 never exceeds the frame width, so a non-empty extent fits in CW bits
    w     = CW'(x1 - {1'b0, x0});
    h     = CW'(y1 - {1'b0, y0});
  end
endmodule

// File: rtl/draw_cmd_seq.sv
// draw_cmd_seq: display-list sequencer; pops FIFO commands, clips PATBLT rects, issues fill jobs; ports: FIFO (cmd_*), fill job (pat_*), status (busy/err/irq)
module draw_cmd_seq
  import draw_cmd_pkg::*;
#(
  parameter int COORD_W = CW,
  parameter int ADDR_W  = 32
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               start,
  input  logic [31:0]        cmd_dout,
  input  logic               cmd_empty,
  output logic               cmd_rd,
  output logic               pat_valid,
  input  logic               pat_ready,
  input  logic               pat_done,
  output logic [ADDR_W-1:0]  pat_addr,
  output logic [ADDR_W-1:0]  pat_pitch,
  output logic [COORD_W-1:0] pat_w,
  output logic [COORD_W-1:0] pat_h,
  output logic [31:0]        pat_color,
  output logic               busy,
  output logic               err,
  output logic               irq
);
  state_t               state;
  logic [7:0]           op, opc;
  logic [ADDR_W-1:0]    vram;
  logic [COORD_W-1:0]   fw, fh, hi, lo, cx0, cy0;
  logic [CW-1:0]        x0, y0, w, h;
  logic                 empty, unused_bits;
  rect_t                area, pat;
  logic [31:0]          color;
  assign opc         = cmd_dout[31:24];
  assign hi          = cmd_dout[16+COORD_W-1:16];
  assign lo          = cmd_dout[COORD_W-1:0];
  assign unused_bits = ^cmd_dout[15:COORD_W];
  assign cmd_rd      = (state == S_OP || state == S_ARG1 || state == S_ARG2) && !cmd_empty;
  assign pat_color   = color;
  draw_clip u_clip (
    .pat  (pat),
    .area (area),
    .fw   (fw),
    .fh   (fh),
    .x0   (x0),
    .y0   (y0),
    .w    (w),
    .h    (h),
    .empty(empty)
  );
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= S_IDLE;
      op        <= '0;
      vram      <= '0;
      fw        <= '0;
      fh        <= '0;
      area      <= '0;
      pat       <= '0;
      color     <= '0;
      cx0       <= '0;
      cy0       <= '0;
      pat_valid <= 1'b0;
      pat_addr  <= '0;
      pat_pitch <= '0;
      pat_w     <= '0;
      pat_h     <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
      irq       <= 1'b0;
    end else begin
      irq <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state <= S_OP;
          busy  <= 1'b1;
          err   <= 1'b0;
        end
        S_OP: if (!cmd_empty) begin
          op    <= opc;
          state <= opc == OP_EODL ? S_FIN :
                   (opc == OP_SETFRAME || opc == OP_SETDRAWAREA ||
                    opc == OP_SETFCOLOR || opc == OP_PATBLT) ? S_ARG1 : S_ERR;
        end
        S_ARG1: if (!cmd_empty) begin
          if (op == OP_SETFRAME) vram <= cmd_dout[ADDR_W-1:0];
          if (op == OP_SETDRAWAREA) begin
            area.x <= hi;
            area.y <= lo;
          end
          if (op == OP_SETFCOLOR) color <= {8'h00, cmd_dout[23:0]};
          if (op == OP_PATBLT) begin
            pat.x <= hi;
            pat.y <= lo;
          end
          state <= op == OP_SETFCOLOR ? S_OP : S_ARG2;
        end
        S_ARG2: if (!cmd_empty) begin
          if (op == OP_SETFRAME) begin
            fw <= hi;
            fh <= lo;
          end
          if (op == OP_SETDRAWAREA) begin
            area.w <= hi;
            area.h <= lo;
          end
          if (op == OP_PATBLT) begin
            pat.w <= hi;
            pat.h <= lo;
          end
          state <= op == OP_PATBLT ? S_CLIP : S_OP;
        end
        S_CLIP: begin
          if (!empty) begin
            cx0   <= x0;
            cy0   <= y0;
            pat_w <= w;
            pat_h <= h;
          end
          state <= empty ? S_OP : S_ADDR;
        end
        S_ADDR: begin
          pat_addr  <= vram + ((ADDR_W'(cy0) * ADDR_W'(fw) + ADDR_W'(cx0)) << 2);
          pat_pitch <= ADDR_W'(fw) << 2;
          pat_valid <= 1'b1;
          state     <= S_ISSUE;
        end
        S_ISSUE: if (pat_ready) begin
          pat_valid <= 1'b0;
          state     <= S_WAIT;
        end
        S_WAIT: if (pat_done) state <= S_OP;
        S_FIN: begin
          irq   <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_ERR: begin
          err   <= 1'b1;
          irq   <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
